core_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV32I core. Fetches each instruction over a valid/request handshake and steps it through decode, execute, memory and writeback. Issues one-cycle enables to the decoder, ALU and register file, and owns the program counter and retired-instruction count. It is the controller that drives `control_unit` and the ALU datapath one instruction at a time.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/core_sequencer_if.sv | 30 +++
 rtl/opclass_decode.sv | 30 +++
 rtl/core_sequencer.sv | 110 +++++++++++
 tb/tb_core_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core.
// Holds the sequencer state type, the instruction-class type, the base
// opcodes (also used by control_unit) and the default reset PC, plus two
// small class predicates used by the sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } seq_state_t;

  typedef enum logic [3:0] {
    OC_R,
    OC_IALU,
    OC_LOAD,
    OC_STORE,
    OC_LUI,
    OC_AUIPC,
    OC_BRANCH,
    OC_JAL,
    OC_JALR,
    OC_NONE
  } opclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Classes that produce a register result (rd == 0 is filtered separately).
  function automatic logic writes_rd(opclass_t c);
    return !(c == OC_STORE || c == OC_BRANCH || c == OC_NONE);
  endfunction

  // Unconditional redirects.
  function automatic logic is_jump(opclass_t c);
    return (c == OC_JAL) || (c == OC_JALR);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle of the core sequencer.
//   imem_req/imem_addr   -> fetch request and address (held until imem_valid)
//   imem_valid/imem_rdata <- fetch completion and instruction word
//   dmem_req/dmem_we/dmem_addr -> data access (held until dmem_ack)
//   dmem_ack             <- data access completion
// master: sequencer side; slave: memory side.
interface core_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
    input  imem_valid, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr,
    output imem_valid, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/opclass_decode.sv
// Combinational opcode classifier.
//   opcode  in  7   instruction bits [6:0]
//   opclass out     instruction class (OC_NONE when illegal)
//   legal   out 1   1 when opcode is one of the supported RV32I classes
module opclass_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass,
  output logic       legal
);

  always_comb begin
    opclass = OC_NONE;
    legal   = 1'b1;
    case (opcode)
      OP_R:      opclass = OC_R;
      OP_IALU:   opclass = OC_IALU;
      OP_LOAD:   opclass = OC_LOAD;
      OP_STORE:  opclass = OC_STORE;
      OP_LUI:    opclass = OC_LUI;
      OP_AUIPC:  opclass = OC_AUIPC;
      OP_BRANCH: opclass = OC_BRANCH;
      OP_JAL:    opclass = OC_JAL;
      OP_JALR:   opclass = OC_JALR;
      default:   legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// WRITEBACK, with a sticky TRAP state left only through reset_n.
//   clock, reset_n      clock (rising edge), asynchronous active-low reset
//   bus (master)        imem/dmem handshakes, see core_sequencer_if
//   inst_q, pc_q        latched instruction and its PC
//   decode_en, exec_en  one-cycle strobes in DECODE / EXECUTE
//   br_taken, target_addr, alu_result  datapath results sampled in EXECUTE
//   rf_we               register-file write strobe in WRITEBACK
//   trap                fault flag (state == TRAP)
//   instret             retired-instruction count
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset_n,
  core_sequencer_if.master bus,
  output logic [31:0]      inst_q,
  output logic [XLEN-1:0]  pc_q,
  output logic             decode_en,
  output logic             exec_en,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  target_addr,
  input  logic [XLEN-1:0]  alu_result,
  output logic             rf_we,
  output logic             trap,
  output logic [63:0]      instret
);

  seq_state_t      state;
  opclass_t        opclass;
  logic            legal;
  logic            redirect;
  logic            redirect_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] addr_q;

  // Classification is a pure function of the latched instruction, so it
  // stays valid from DECODE through WRITEBACK without a class register.
  opclass_decode u_opclass_decode (
    .opcode  (inst_q[6:0]),
    .opclass (opclass),
    .legal   (legal)
  );

  assign redirect = is_jump(opclass) || ((opclass == OC_BRANCH) && br_taken);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      instret    <= '0;
      redirect_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.imem_valid) begin
            inst_q <= bus.imem_rdata;
            state  <= S_DECODE;
          end
        end
        S_DECODE: state <= legal ? S_EXECUTE : S_TRAP;
        S_EXECUTE: begin
          redirect_q <= redirect;
          // Only bit 1 matters: bit 0 of a target is always discarded.
          if (redirect && target_addr[1])
            state <= S_TRAP;
          else if ((opclass == OC_LOAD) || (opclass == OC_STORE))
            state <= S_MEM;
          else
            state <= S_WRITEBACK;
        end
        S_MEM: begin
          if (bus.dmem_ack) state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc_q    <= redirect_q ? (target_q & ~XLEN'(1)) : (pc_q + XLEN'(4));
          instret <= instret + 64'd1;
          state   <= S_FETCH;
        end
        S_TRAP: ;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Datapath captures carry no reset; they are only consumed after EXECUTE.
  always_ff @(posedge clock) begin
    if (state == S_EXECUTE) begin
      target_q <= target_addr;
      addr_q   <= alu_result;
    end
  end

  // The reset state is FETCH, so the fetch request is also gated by reset_n
  // to keep it low while reset is held and drop it as soon as reset asserts.
  assign bus.imem_req  = reset_n && (state == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = (state == S_MEM);
  assign bus.dmem_we   = (state == S_MEM) && (opclass == OC_STORE);
  assign bus.dmem_addr = addr_q;
  assign decode_en     = (state == S_DECODE);
  assign exec_en       = (state == S_EXECUTE);
  assign rf_we         = (state == S_WRITEBACK) && writes_rd(opclass) && (inst_q[11:7] != 5'd0);
  assign trap          = (state == S_TRAP);

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. A transaction-level model turns each
// directed instruction (word, wait states, branch inputs) into a list of
// per-cycle input/expected-output records; a driver plays them and one
// compare process checks the DUT on every cycle. Literal checks pin PCs,
// counts and latencies. A second instance covers PC wrap-around.
module tb_core_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        br_taken;
  logic [31:0] target_addr, alu_result;
  logic [31:0] inst_q, pc_q;
  logic        decode_en, exec_en, rf_we, trap;
  logic [63:0] instret;

  core_sequencer_if #(.XLEN(32)) bus ();

  core_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .inst_q(inst_q), .pc_q(pc_q), .decode_en(decode_en), .exec_en(exec_en),
    .br_taken(br_taken), .target_addr(target_addr), .alu_result(alu_result),
    .rf_we(rf_we), .trap(trap), .instret(instret)
  );

  // Second instance: reset PC at the top of the address space.
  logic        reset_n2, br2;
  logic [31:0] tgt2, alu2, inst2, pc2;
  logic        dec2, exe2, rfwe2, trap2;
  logic [63:0] instret2;

  core_sequencer_if #(.XLEN(32)) bus2 ();

  core_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset_n(reset_n2), .bus(bus2),
    .inst_q(inst2), .pc_q(pc2), .decode_en(dec2), .exec_en(exe2),
    .br_taken(br2), .target_addr(tgt2), .alu_result(alu2),
    .rf_we(rfwe2), .trap(trap2), .instret(instret2)
  );

  typedef struct {
    logic        rst_n, ivalid, br, ack;
    logic [31:0] rdata, tgt, alu;
    logic        ireq, dec, exe, dreq, dwe, rfwe, trp;
    logic [31:0] iaddr, daddr, pc, inst;
    logic [63:0] ret;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   cur_vld = 1'b0;
  bit   noise   = 1'b0;

  // Architectural model state
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_ret;
  bit          m_trap;

  int n_checks = 0, n_err = 0;
  int cyc_n = 0, last_rfwe = 0;
  int n_rfwe = 0, n_dreq = 0, n_act = 0;

  localparam int K_ILL = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JMP = 5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h37, 7'h17: return K_ALU;
      7'h03:                      return K_LOAD;
      7'h23:                      return K_STORE;
      7'h63:                      return K_BR;
      7'h6F, 7'h67:               return K_JMP;
      default:                    return K_ILL;
    endcase
  endfunction

  // A cycle where nothing is expected to happen; inputs carry junk.
  function automatic cyc_t blank();
    cyc_t c;
    c.rst_n = 1'b1;  c.ivalid = noise;  c.ack = noise;
    c.br    = 1'($urandom_range(0, 1));
    c.rdata = $urandom;  c.tgt = $urandom;  c.alu = $urandom;
    c.ireq  = 1'b0;  c.dec = 1'b0;  c.exe = 1'b0;  c.dreq = 1'b0;
    c.dwe   = 1'b0;  c.rfwe = 1'b0;  c.trp = m_trap;
    c.iaddr = m_pc;  c.daddr = 32'h0;  c.pc = m_pc;  c.inst = m_inst;  c.ret = m_ret;
    return c;
  endfunction

  task automatic add_reset(input int n);
    cyc_t c;
    m_pc = 32'h0;  m_inst = 32'h0;  m_ret = 64'h0;  m_trap = 1'b0;
    repeat (n) begin
      c = blank();
      c.rst_n = 1'b0;
      q.push_back(c);
    end
  endtask

  task automatic add_idle(input int n);
    cyc_t c;
    repeat (n) begin
      c = blank();
      if (!m_trap) begin
        c.ireq   = 1'b1;
        c.ivalid = 1'b0;
      end
      q.push_back(c);
    end
  endtask

  task automatic add_instr(input logic [31:0] w, input int fw, input int mw, input logic br,
                           input logic [31:0] tgt, input logic [31:0] alu, input bit abort_mem);
    cyc_t c;
    int   k;
    bit   redir;
    k = kind_of(w);
    for (int i = 0; i <= fw; i++) begin
      c = blank();
      c.ireq   = 1'b1;
      c.ivalid = (i == fw);
      if (i == fw) c.rdata = w;
      q.push_back(c);
    end
    m_inst = w;
    c = blank();  c.dec = 1'b1;  q.push_back(c);
    if (k == K_ILL) begin
      m_trap = 1'b1;
      return;
    end
    c = blank();  c.exe = 1'b1;  c.br = br;  c.tgt = tgt;  c.alu = alu;  q.push_back(c);
    redir = (k == K_JMP) || ((k == K_BR) && br);
    if (redir && tgt[1]) begin
      m_trap = 1'b1;
      return;
    end
    if ((k == K_LOAD) || (k == K_STORE)) begin
      for (int i = 0; i <= mw; i++) begin
        c = blank();
        c.dreq = 1'b1;  c.dwe = (k == K_STORE);  c.daddr = alu;
        c.ack  = (i == mw) && !abort_mem;
        q.push_back(c);
      end
      if (abort_mem) return;
    end
    c = blank();
    c.rfwe = (k != K_STORE) && (k != K_BR) && (w[11:7] != 5'd0);
    q.push_back(c);
    m_pc  = redir ? {tgt[31:1], 1'b0} : m_pc + 32'd4;
    m_ret = m_ret + 64'd1;
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      @(posedge clock); #1;
      cur = q.pop_front();
      reset_n = cur.rst_n;  bus.imem_valid = cur.ivalid;  bus.imem_rdata = cur.rdata;
      br_taken = cur.br;  target_addr = cur.tgt;  alu_result = cur.alu;  bus.dmem_ack = cur.ack;
      cyc_n++;
      cur_vld = 1'b1;
    end
  endtask

  // Play the queue, then stand just after the last cycle's compare.
  task automatic step();
    run_queue();
    @(negedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (cur_vld) begin
      chk("imem_req", 64'(bus.imem_req), 64'(cur.ireq));
      if (cur.ireq) chk("imem_addr", 64'(bus.imem_addr), 64'(cur.iaddr));
      chk("decode_en", 64'(decode_en), 64'(cur.dec));
      chk("exec_en", 64'(exec_en), 64'(cur.exe));
      chk("dmem_req", 64'(bus.dmem_req), 64'(cur.dreq));
      chk("dmem_we", 64'(bus.dmem_we), 64'(cur.dwe));
      if (cur.dreq) chk("dmem_addr", 64'(bus.dmem_addr), 64'(cur.daddr));
      chk("rf_we", 64'(rf_we), 64'(cur.rfwe));
      chk("trap", 64'(trap), 64'(cur.trp));
      chk("pc_q", 64'(pc_q), 64'(cur.pc));
      chk("inst_q", 64'(inst_q), 64'(cur.inst));
      chk("instret", instret, cur.ret);
      if (rf_we) begin
        n_rfwe++;
        last_rfwe = cyc_n;
      end
      if (bus.dmem_req) n_dreq++;
      if (decode_en || exec_en || rf_we || bus.imem_req || bus.dmem_req) n_act++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;

  initial begin
    int s, r0, d0, a0;
    reset_n = 1'b0;  br_taken = 1'b0;  target_addr = '0;  alu_result = '0;
    bus.imem_valid = 1'b0;  bus.imem_rdata = '0;  bus.dmem_ack = 1'b0;
    m_pc = '0;  m_inst = '0;  m_ret = '0;  m_trap = 1'b0;

    // PC wrap on the second instance
    reset_n2 = 1'b0;  br2 = 1'b0;  tgt2 = '0;  alu2 = '0;
    bus2.imem_valid = 1'b1;  bus2.imem_rdata = NOP;  bus2.dmem_ack = 1'b0;
    @(negedge clock);
    chk("wrap_rst_pc", 64'(pc2), 64'hFFFF_FFFC);
    chk("wrap_rst_ireq", 64'(bus2.imem_req), 64'd0);
    @(posedge clock); #1;
    reset_n2 = 1'b1;
    @(negedge clock);
    chk("wrap_first_ireq", 64'(bus2.imem_req), 64'd1);
    chk("wrap_first_addr", 64'(bus2.imem_addr), 64'hFFFF_FFFC);
    repeat (4) @(posedge clock);
    #1;
    chk("wrap_pc", 64'(pc2), 64'd0);
    chk("wrap_instret", instret2, 64'd1);
    reset_n2 = 1'b0;

    // Reset state
    add_reset(3);  step();
    chk("rst_ireq", 64'(bus.imem_req), 64'd0);
    chk("rst_pc", 64'(pc_q), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);

    // ADDI right after reset release, zero wait
    s = cyc_n;  r0 = n_rfwe;
    add_instr(ADDI, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("addi_pc", 64'(pc_q), 64'd4);
    chk("addi_instret", instret, 64'd1);
    chk("addi_rfwe_pulses", 64'(n_rfwe - r0), 64'd1);
    chk("addi_latency", 64'(last_rfwe - s), 64'd4);

    // LOAD with dmem_ack after two wait cycles
    s = cyc_n;  r0 = n_rfwe;  d0 = n_dreq;
    add_instr(32'h0000_2183, 0, 2, 1'b0, 32'h0, 32'h100, 1'b0);  add_idle(1);  step();
    chk("load_pc", 64'(pc_q), 64'd8);
    chk("load_dreq_cycles", 64'(n_dreq - d0), 64'd3);
    chk("load_rfwe_pulses", 64'(n_rfwe - r0), 64'd1);
    chk("load_latency", 64'(last_rfwe - s), 64'd7);

    // Taken BEQ from pc 8
    r0 = n_rfwe;
    add_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40, 32'h0, 1'b0);  add_idle(1);  step();
    chk("beq_taken_pc", 64'(pc_q), 64'h40);
    chk("beq_no_rfwe", 64'(n_rfwe - r0), 64'd0);

    // ADD with three fetch wait cycles
    s = cyc_n;
    add_instr(32'h0010_8133, 3, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("stall_latency", 64'(last_rfwe - s), 64'd7);
    chk("stall_pc", 64'(pc_q), 64'h44);
    chk("stall_instret", instret, 64'd4);

    // Stray handshakes and junk inputs from here on
    noise = 1'b1;
    r0 = n_rfwe;  d0 = n_dreq;
    add_instr(32'h0011_2023, 0, 0, 1'b0, 32'h0, 32'h204, 1'b0);  add_idle(1);  step();
    chk("store_pc", 64'(pc_q), 64'h48);
    chk("store_no_rfwe", 64'(n_rfwe - r0), 64'd0);
    chk("store_dreq_cycles", 64'(n_dreq - d0), 64'd1);

    add_instr(32'h0002_80E7, 0, 0, 1'b1, 32'h101, 32'h0, 1'b0);  add_idle(1);  step();
    chk("jalr_pc_bit0_cleared", 64'(pc_q), 64'h100);
    add_instr(32'h1234_52B7, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    r0 = n_rfwe;
    add_instr(32'h0010_0013, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("rd0_pc", 64'(pc_q), 64'h108);
    chk("rd0_rfwe_only_lui", 64'(n_rfwe - r0), 64'd1);
    add_instr(32'h0000_0063, 0, 0, 1'b1, 32'h11, 32'h0, 1'b0);  add_idle(1);  step();
    chk("beq_odd_target_pc", 64'(pc_q), 64'h10);

    // Reset in the middle of MEM, then in the middle of FETCH
    add_instr(32'h0000_2183, 0, 5, 1'b0, 32'h0, 32'h300, 1'b1);  add_reset(2);  step();
    chk("midmem_dreq", 64'(bus.dmem_req), 64'd0);
    chk("midmem_instret", instret, 64'd0);
    add_idle(2);  add_reset(1);
    add_instr(ADDI, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("after_midfetch_pc", 64'(pc_q), 64'd4);
    chk("after_midfetch_instret", instret, 64'd1);

    // Not-taken BEQ from pc 8
    add_reset(1);
    add_instr(NOP, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    add_instr(NOP, 1, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    add_instr(32'h0000_0063, 0, 0, 1'b0, 32'h40, 32'h0, 1'b0);  add_idle(1);  step();
    chk("beq_not_taken_pc", 64'(pc_q), 64'd12);
    chk("beq_not_taken_instret", instret, 64'd3);

    // Misaligned JAL from pc 8
    add_reset(1);
    add_instr(NOP, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    add_instr(NOP, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    add_instr(32'h0000_00EF, 0, 0, 1'b0, 32'h42, 32'h0, 1'b0);  add_idle(1);  step();
    chk("jal_misaligned_trap", 64'(trap), 64'd1);
    chk("jal_misaligned_pc", 64'(pc_q), 64'd8);
    chk("jal_misaligned_instret", instret, 64'd2);
    a0 = n_act;
    add_idle(10);  step();
    chk("jal_trap_quiet", 64'(n_act - a0), 64'd0);

    // Reset recovery from trap
    add_reset(1);  step();
    chk("recover_trap", 64'(trap), 64'd0);
    chk("recover_pc", 64'(pc_q), 64'd0);
    add_instr(ADDI, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("recover_fetch_pc", 64'(pc_q), 64'd4);

    // Illegal opcode
    add_instr(32'hFFFF_FFFF, 1, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("illegal_trap", 64'(trap), 64'd1);
    chk("illegal_pc", 64'(pc_q), 64'd4);
    chk("illegal_inst", 64'(inst_q), 64'hFFFF_FFFF);
    a0 = n_act;
    add_idle(10);  step();
    chk("illegal_trap_quiet", 64'(n_act - a0), 64'd0);
    add_reset(2);
    add_instr(ADDI, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0);  add_idle(1);  step();
    chk("illegal_recover_trap", 64'(trap), 64'd0);
    chk("illegal_recover_pc", 64'(pc_q), 64'd4);

    cur_vld = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
